// File: rtl/startup_seq_pkg.sv
// Shared definitions for the startup reset sequencer.
//   state_t       : FSM state encoding, also exported on state_o for debug
//   CNT_W         : width of the hold and timeout counters
//   fifo_rst_for  : fifo_rst level to be driven while in a given state
package startup_seq_pkg;

   typedef enum logic [2:0] {
      RESET        = 3'd0,
      WAIT_STARTUP = 3'd1,
      HOLD         = 3'd2,
      WAIT_ACK     = 3'd3,
      RUN          = 3'd4,
      ERR          = 3'd5
   } state_t;

   localparam int unsigned CNT_W = 16;

   // The FIFO is released only while its init handshake runs and after it succeeds.
   function automatic logic fifo_rst_for(input state_t s);
      return !((s == WAIT_ACK) || (s == RUN));
   endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Flop chain bringing an asynchronous level into the clk domain.
//   clk : sampling clock
//   rst : synchronous active-high reset, loads every stage with INIT
//   d   : asynchronous input level
//   q   : synchronized output (last stage)
module reset_sync_chain #(
   parameter int unsigned STAGES = 2,
   parameter logic        INIT   = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= {STAGES{INIT}};
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/startup_reset_seq.sv
// Sequences the reset of a downstream FIFO after device startup.
//   clk            : single clock, rising edge
//   rst            : synchronous active-high reset
//   startup_i      : asynchronous startup-active flag (high during startup)
//   soft_rst_req   : single-cycle request to re-run the reset sequence
//   fifo_init_done : level from the FIFO, high once its flush is complete
//   fifo_rst       : active-high reset to the FIFO (registered)
//   ready          : high only while in RUN (registered)
//   timeout_err    : sticky init-timeout flag, cleared only by rst (registered)
//   state_o        : current FSM state encoding, for debug
module startup_reset_seq
   import startup_seq_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES    = 16,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       startup_i,
   input  logic       soft_rst_req,
   input  logic       fifo_init_done,
   output logic       fifo_rst,
   output logic       ready,
   output logic       timeout_err,
   output logic [2:0] state_o
);

   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic             startup_s;
   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] hold_cnt;
   logic [CNT_W-1:0] to_cnt;
   logic             hold_clr;
   logic             hold_inc;
   logic             to_clr;
   logic             to_inc;
   logic             err_set;

   reset_sync_chain #(
      .STAGES (SYNC_STAGES),
      .INIT   (1'b1)
   ) u_startup_sync (
      .clk (clk),
      .rst (rst),
      .d   (startup_i),
      .q   (startup_s)
   );

   // Priority in every active state: startup_s, then soft_rst_req, then local progress.
   always_comb begin
      state_nxt = state;
      hold_clr  = 1'b0;
      hold_inc  = 1'b0;
      to_clr    = 1'b0;
      to_inc    = 1'b0;
      err_set   = 1'b0;
      case (state)
         RESET: state_nxt = WAIT_STARTUP;
         WAIT_STARTUP: begin
            if (!startup_s) begin
               state_nxt = HOLD;
               hold_clr  = 1'b1;
            end
         end
         HOLD: begin
            if (startup_s) begin
               state_nxt = WAIT_STARTUP;
            end else if (soft_rst_req) begin
               hold_clr = 1'b1;
            end else if (hold_cnt == HOLD_LAST) begin
               state_nxt = WAIT_ACK;
               to_clr    = 1'b1;
            end else begin
               hold_inc = 1'b1;
            end
         end
         WAIT_ACK: begin
            if (startup_s) begin
               state_nxt = WAIT_STARTUP;
            end else if (soft_rst_req) begin
               state_nxt = HOLD;
               hold_clr  = 1'b1;
            end else if (fifo_init_done) begin
               state_nxt = RUN;
            end else if (to_cnt == TIMEOUT_LAST) begin
               state_nxt = ERR;
               err_set   = 1'b1;
            end else begin
               to_inc = 1'b1;
            end
         end
         RUN, ERR: begin
            if (startup_s) begin
               state_nxt = WAIT_STARTUP;
            end else if (soft_rst_req) begin
               state_nxt = HOLD;
               hold_clr  = 1'b1;
            end
         end
         default: state_nxt = RESET;
      endcase
   end

   // Outputs are decoded from the next state so they register in step with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RESET;
         fifo_rst    <= 1'b1;
         ready       <= 1'b0;
         timeout_err <= 1'b0;
         hold_cnt    <= '0;
         to_cnt      <= '0;
      end else begin
         state    <= state_nxt;
         fifo_rst <= fifo_rst_for(state_nxt);
         ready    <= (state_nxt == RUN);
         if (err_set) begin
            timeout_err <= 1'b1;
         end
         if (hold_clr) begin
            hold_cnt <= '0;
         end else if (hold_inc) begin
            hold_cnt <= hold_cnt + 1'b1;
         end
         if (to_clr) begin
            to_cnt <= '0;
         end else if (to_inc) begin
            to_cnt <= to_cnt + 1'b1;
         end
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_startup_reset_seq.sv
module tb_startup_reset_seq;

   // Expected observation = {state_o, fifo_rst, ready, timeout_err}
   localparam logic [5:0] O_RESET = 6'b000_1_0_0;
   localparam logic [5:0] O_WS    = 6'b001_1_0_0;
   localparam logic [5:0] O_HOLD  = 6'b010_1_0_0;
   localparam logic [5:0] O_WA    = 6'b011_0_0_0;
   localparam logic [5:0] O_RUN   = 6'b100_0_1_0;
   localparam logic [5:0] O_ERR   = 6'b101_1_0_0;

   logic       clk = 1'b0;
   logic       rst;
   logic       startup_i;
   logic       soft_rst_req;
   logic       fifo_init_done;
   logic       fifo_rst;
   logic       ready;
   logic       timeout_err;
   logic [2:0] state_o;
   logic [5:0] obs;
   logic       terr_exp;

   int total = 0;
   int bad   = 0;

   startup_reset_seq #(
      .HOLD_CYCLES    (4),
      .SYNC_STAGES    (2),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .startup_i      (startup_i),
      .soft_rst_req   (soft_rst_req),
      .fifo_init_done (fifo_init_done),
      .fifo_rst       (fifo_rst),
      .ready          (ready),
      .timeout_err    (timeout_err),
      .state_o        (state_o)
   );

   always #5 clk = ~clk;

   assign obs = {state_o, fifo_rst, ready, timeout_err};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; startup_i = 1'b0; soft_rst_req = 1'b0; fifo_init_done = 1'b1;
      terr_exp = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (obs !== O_RESET) begin
            bad++;
            $display("FAIL reset[%0d] obs=%b exp=%b", i, obs, O_RESET);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_startup_sequence();
      logic [5:0] tab [12] = '{O_WS, O_WS, O_HOLD, O_HOLD, O_HOLD, O_HOLD,
                               O_WA, O_RUN, O_RUN, O_RUN, O_RUN, O_RUN};
      for (int i = 0; i < 12; i++) begin
         if (i == 9) fifo_init_done = 1'b0;   // falls in RUN: must stay in RUN
         if (i == 11) fifo_init_done = 1'b1;
         tick();
         total++;
         if (obs !== tab[i]) begin
            bad++;
            $display("FAIL startup_seq[%0d] obs=%b exp=%b", i, obs, tab[i]);
         end
      end
   endtask

   task automatic test_soft_reset_in_run();
      logic [5:0] tab [6] = '{O_HOLD, O_HOLD, O_HOLD, O_HOLD, O_WA, O_RUN};
      soft_rst_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         soft_rst_req = 1'b0;
         total++;
         if (obs !== tab[i]) begin
            bad++;
            $display("FAIL soft_in_run[%0d] obs=%b exp=%b", i, obs, tab[i]);
         end
      end
   endtask

   task automatic test_timeout();
      logic [5:0] exp;
      fifo_init_done = 1'b0;
      soft_rst_req   = 1'b1;
      // 4 HOLD, 8 WAIT_ACK, then ERR with the sticky flag, held 3 cycles
      for (int i = 0; i < 15; i++) begin
         tick();
         soft_rst_req = 1'b0;
         if (i < 4)       exp = O_HOLD;
         else if (i < 12) exp = O_WA;
         else             exp = O_ERR | 6'b000001;
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL timeout[%0d] obs=%b exp=%b", i, obs, exp);
         end
      end
      terr_exp = 1'b1;
      soft_rst_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         soft_rst_req   = 1'b0;
         fifo_init_done = 1'b1;
         if (i < 4)       exp = O_HOLD;
         else if (i == 4) exp = O_WA;
         else             exp = O_RUN;
         exp[0] = terr_exp;
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL err_recover[%0d] obs=%b exp=%b", i, obs, exp);
         end
      end
   endtask

   task automatic test_startup_reentry();
      logic [5:0] tab [11] = '{O_RUN, O_RUN, O_WS, O_WS, O_WS,
                               O_HOLD, O_HOLD, O_HOLD, O_HOLD, O_WA, O_RUN};
      logic [5:0] exp;
      startup_i = 1'b1;
      for (int i = 0; i < 11; i++) begin
         tick();
         if (i == 2) startup_i = 1'b0;
         exp    = tab[i];
         exp[0] = terr_exp;
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL startup_reentry[%0d] obs=%b exp=%b", i, obs, exp);
         end
      end
   endtask

   task automatic test_startup_beats_soft();
      logic [5:0] exp;
      int         n;
      startup_i = 1'b1;
      tick();
      tick();                // synchronizer output now 1
      soft_rst_req = 1'b1;
      tick();
      soft_rst_req = 1'b0;
      startup_i    = 1'b0;
      exp    = O_WS;
      exp[0] = terr_exp;
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL startup_over_soft obs=%b exp=%b", obs, exp);
      end
      n = 0;
      while (state_o !== 3'd4 && n < 20) begin
         tick();
         n++;
      end
      total++;
      if (state_o !== 3'd4) begin
         bad++;
         $display("FAIL startup_over_soft_return state=%0d exp=4", state_o);
      end
   endtask

   task automatic test_rst_mid_hold();
      logic [5:0] tab [8] = '{O_WS, O_WS, O_HOLD, O_HOLD, O_HOLD, O_HOLD, O_WA, O_RUN};
      soft_rst_req = 1'b1;
      tick();                // HOLD cycle 1
      soft_rst_req = 1'b0;
      tick();                // HOLD cycle 2
      rst = 1'b1;
      tick();
      terr_exp = 1'b0;
      total++;
      if (obs !== O_RESET) begin
         bad++;
         $display("FAIL rst_mid_hold obs=%b exp=%b", obs, O_RESET);
      end
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         total++;
         if (obs !== tab[i]) begin
            bad++;
            $display("FAIL rst_restart[%0d] obs=%b exp=%b", i, obs, tab[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_startup_sequence();
      test_soft_reset_in_run();
      test_timeout();
      test_startup_reentry();
      test_startup_beats_soft();
      test_rst_mid_hold();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/startup_reset_seq.md
STARTUP_RESET_SEQ -- requirements
Module: startup_reset_seq

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16: cycles fifo_rst is held in HOLD before release; legal range 1..65535.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flop depth of the startup_i synchronizer; legal range 2..4.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256: maximum cycles spent waiting for fifo_init_done; legal range 1..65535.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port startup_i, input, 1 bit: asynchronous startup-active flag (GSR-style), high while the device is still in startup.
REQ-007 SHALL have port soft_rst_req, input, 1 bit: single-cycle synchronous request to re-run the reset sequence.
REQ-008 SHALL have port fifo_init_done, input, 1 bit: level from the downstream FIFO, high once its flush is complete.
REQ-009 SHALL have port fifo_rst, output, 1 bit: reset to the downstream FIFO, active-high.
REQ-010 SHALL have port ready, output, 1 bit: high while the FIFO is out of reset and initialised.
REQ-011 SHALL have port timeout_err, output, 1 bit: sticky flag, set when the init wait times out.
REQ-012 SHALL have port state_o, output, 3 bits: current FSM state encoding, for debug.

Function
REQ-013 SHALL pass startup_i through a SYNC_STAGES-deep flop chain to produce startup_s; no other logic shall use startup_i.
REQ-014 SHALL implement states RESET, WAIT_STARTUP, HOLD, WAIT_ACK, RUN, ERR.
REQ-015 SHALL go RESET -> WAIT_STARTUP on the first cycle after rst deasserts.
REQ-016 SHALL go WAIT_STARTUP -> HOLD when startup_s is 0.
REQ-017 SHALL, in HOLD, clear the hold counter on entry, increment it each cycle, and go to WAIT_ACK when count equals HOLD_CYCLES-1, so HOLD lasts exactly HOLD_CYCLES cycles.
REQ-018 SHALL, in WAIT_ACK, clear the timeout counter on entry and go to RUN on the first cycle fifo_init_done is 1.
REQ-019 SHALL, in WAIT_ACK, go to ERR and set timeout_err when TIMEOUT_CYCLES cycles elapse without fifo_init_done.
REQ-020 SHALL go from RUN, WAIT_ACK, HOLD or ERR to HOLD on soft_rst_req, restarting the hold counter.
REQ-021 SHALL go from any state other than RESET to WAIT_STARTUP when startup_s is 1; this takes priority over soft_rst_req and over timeout.
REQ-022 SHALL, in ERR, hold until soft_rst_req, startup_s or rst.
REQ-023 SHALL drive fifo_rst=1 in RESET, WAIT_STARTUP, HOLD and ERR, and 0 in WAIT_ACK and RUN.
REQ-024 SHALL drive ready=1 only in RUN.
REQ-025 SHALL, if fifo_init_done falls while in RUN, stay in RUN (the input is sampled only in WAIT_ACK).
REQ-026 SHALL drive fifo_rst, ready, timeout_err and state_o directly from flops, with no combinational path from inputs to outputs.
REQ-027 SHALL keep timeout_err set until rst; soft_rst_req shall not clear it.

Reset
REQ-028 SHALL, while rst=1, force state RESET, fifo_rst=1, ready=0, timeout_err=0, both counters 0, and all synchronizer flops to 1.
REQ-029 SHALL, when rst asserts mid-sequence, show reset values at the outputs on the next clock edge.

Structure
REQ-030 SHALL place the state encoding (3-bit enum, RESET=0 through ERR=5) and counter-width constants in shared package startup_seq_pkg.
REQ-031 SHALL implement the synchronizer as sub-module reset_sync_chain, with parameters STAGES and INIT and ports clk, rst, d, q.

Verification (HOLD_CYCLES=4, SYNC_STAGES=2, TIMEOUT_CYCLES=8)
REQ-032 SHALL check: rst high 3 cycles, startup_i=0, fifo_init_done tied 1 -> fifo_rst is 1 through 4 HOLD cycles and falls on WAIT_ACK entry; ready rises exactly 1 cycle later.
REQ-033 SHALL check: fifo_init_done held 0 -> ERR exactly 8 cycles after WAIT_ACK entry, with timeout_err=1 and fifo_rst=1; then soft_rst_req -> HOLD, and timeout_err stays 1.
REQ-034 SHALL check: soft_rst_req pulse in RUN -> next cycle ready=0 and fifo_rst=1 for 4 cycles, followed by a normal return to RUN.
REQ-035 SHALL check: startup_i raised in RUN -> within 3 cycles state_o=1 (WAIT_STARTUP), fifo_rst=1, ready=0; released -> HOLD after 2 synchronizer cycles.
REQ-036 SHALL check: soft_rst_req in the same cycle startup_s=1 -> WAIT_STARTUP, not HOLD.
REQ-037 SHALL check: rst pulsed on HOLD cycle 2 -> next edge state_o=0, timeout_err=0, and the sequence restarts from RESET.
